seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 76 +++++++
 rtl/seg_decode.sv | 21 ++
 rtl/seg_scan_driver.sv | 115 +++++++++++
 tb/tb_seg_scan_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared glyphs, segment bit positions and dark values for the seven-segment scan driver.
// Codes 10..15 light A..F only when SEG_HEX_EN is defined, otherwise they stay blank.
package seg_pkg;

    // Bit positions inside the active-low segment byte.
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Seven-segment glyphs ordered a..g from MSB to LSB, 1 = segment off.
    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b1100000;
    localparam logic [6:0] GLYPH_C     = 7'b0110001;
    localparam logic [6:0] GLYPH_D     = 7'b1000010;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_F     = 7'b0111000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph_of(input logic [3:0] code, input logic hex_en);
        logic [6:0] g;
        case (code)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            4'd10:   g = hex_en ? GLYPH_A : GLYPH_BLANK;
            4'd11:   g = hex_en ? GLYPH_B : GLYPH_BLANK;
            4'd12:   g = hex_en ? GLYPH_C : GLYPH_BLANK;
            4'd13:   g = hex_en ? GLYPH_D : GLYPH_BLANK;
            4'd14:   g = hex_en ? GLYPH_E : GLYPH_BLANK;
            4'd15:   g = hex_en ? GLYPH_F : GLYPH_BLANK;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Places a..g and the decimal point into the active-low output byte.
    function automatic logic [7:0] seg_pack(input logic [6:0] seg7, input logic dp_on);
        logic [7:0] v;
        v             = SEG_OFF;
        v[SEG_A_BIT]  = seg7[6];
        v[SEG_B_BIT]  = seg7[5];
        v[SEG_C_BIT]  = seg7[4];
        v[SEG_D_BIT]  = seg7[3];
        v[SEG_E_BIT]  = seg7[2];
        v[SEG_F_BIT]  = seg7[1];
        v[SEG_G_BIT]  = seg7[0];
        v[SEG_DP_BIT] = ~dp_on;
        return v;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Four-bit code to active-low a..g segments.
// Hex letters for codes 10..15 appear only when SEG_HEX_EN is defined.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

`ifdef SEG_HEX_EN
    localparam logic HEX_EN = 1'b1;
`else
    localparam logic HEX_EN = 1'b0;
`endif

    // Pure lookup; the glyph table lives in the package.
    always_comb begin
        o_seg = glyph_of(i_code, HEX_EN);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: per-frame input snapshot, blanked slot starts.
// Build with SEG_HEX_EN defined to show codes 10..15 as A..F instead of blank.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 1024,
    parameter int BLANK = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*NDIG-1:0]     digits,
    input  logic [NDIG-1:0]       dp,
    output logic [NDIG-1:0]       An,
    output logic [7:0]            Cout,
    output logic                  frame_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0]   CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_DARK   = ANODE_OFF[NDIG-1:0];

    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [4*NDIG-1:0] r_shadow_digits;
    logic [NDIG-1:0]   r_shadow_dp;
    logic [NDIG-1:0]   r_an;
    logic [7:0]        r_cout;
    logic              r_frame_start;

    logic [3:0]        w_code;
    logic              w_dp;
    logic [6:0]        w_seg7;
    logic [NDIG-1:0]   w_an_sel;
    logic              w_frame_edge;
    logic              w_dark;

    assign w_frame_edge = en && (r_cnt == {CW{1'b0}}) && (r_idx == {IW{1'b0}});
    assign w_dark       = !en || (r_cnt < CNT_BLANK);

    // Select the shadow code/dp of the current digit and its single low anode.
    always_comb begin
        w_code   = 4'h0;
        w_dp     = 1'b0;
        w_an_sel = AN_DARK;
        for (int i = 0; i < NDIG; i++) begin
            w_code             = (r_idx == IW'(i)) ? r_shadow_digits[4*i +: 4] : w_code;
            w_dp               = (r_idx == IW'(i)) ? r_shadow_dp[i] : w_dp;
            w_an_sel[NDIG-1-i] = (r_idx == IW'(i)) ? 1'b0 : 1'b1;
        end
    end

    seg_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_seg7)
    );

    // Scan position: cleared while disabled, otherwise slot counter then digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CW{1'b0}};
            r_idx <= {IW{1'b0}};
        end else if (!en) begin
            r_cnt <= {CW{1'b0}};
            r_idx <= {IW{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= {CW{1'b0}};
            r_idx <= (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
        end else begin
            r_cnt <= r_cnt + CW'(1);
            r_idx <= r_idx;
        end
    end

    // Inputs are sampled once per frame so a frame never mixes two input values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_digits <= {(4*NDIG){1'b0}};
            r_shadow_dp     <= {NDIG{1'b0}};
            r_frame_start   <= 1'b0;
        end else if (w_frame_edge) begin
            r_shadow_digits <= digits;
            r_shadow_dp     <= dp;
            r_frame_start   <= 1'b1;
        end else begin
            r_shadow_digits <= r_shadow_digits;
            r_shadow_dp     <= r_shadow_dp;
            r_frame_start   <= 1'b0;
        end
    end

    // Registered drive; the blank window at each slot start keeps anodes from overlapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an   <= AN_DARK;
            r_cout <= SEG_OFF;
        end else if (w_dark) begin
            r_an   <= AN_DARK;
            r_cout <= SEG_OFF;
        end else begin
            r_an   <= w_an_sel;
            r_cout <= seg_pack(w_seg7, w_dp);
        end
    end

    assign An          = r_an;
    assign Cout        = r_cout;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (NDIG=4, DIV=8, BLANK=2); honours SEG_HEX_EN.
module tb_seg_scan_driver;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  An;
    logic [7:0]  Cout;
    logic        frame_start;

    seg_scan_driver #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits      (digits),
        .dp          (dp),
        .An          (An),
        .Cout        (Cout),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] cout;
        logic       fs;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          t = 0;              // enabled cycles since scanning (re)started
    logic [15:0] snap_d = 16'h0000;
    logic [3:0]  snap_dp = 4'b0000;
    logic [15:0] cur_d = 16'h0000;
    logic [3:0]  cur_dp = 4'b0000;

    // Display glyphs a..g (MSB = a), 1 = segment off.
    function automatic logic [6:0] ref_glyph(input int code);
        case (code)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
`ifdef SEG_HEX_EN
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
`endif
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, req);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs are computed from the
    // frame position: frame of NDIG slots, each BLANK dark then DIV-BLANK lit cycles.
    task automatic step(input logic e);
        exp_t x;
        int   p, d, ph;
        @(negedge clk);
        en = e; digits = cur_d; dp = cur_dp;
        x.an = 4'hF; x.cout = 8'hFF; x.fs = 1'b0;
        if (!e) begin
            t = 0;
        end else begin
            p = t % FRAME;
            if (p == 0) begin
                snap_d = cur_d; snap_dp = cur_dp; x.fs = 1'b1;
            end
            d  = p / DIV;
            ph = p % DIV;
            if (ph >= BLANK) begin
                x.an[NDIG-1-d] = 1'b0;
                x.cout = {ref_glyph(int'(snap_d[4*d +: 4])), ~snap_dp[d]};
            end
            t++;
        end
        q.push_back(x);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1);
    endtask

    // Advance until the digit `dig` is being shown lit.
    task automatic run_to_lit(input int dig);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (((t % FRAME) / DIV == dig) && ((t % DIV) >= BLANK + 1)) break;
            step(1'b1);
        end
    endtask

    // Monitor: pops one expectation per edge, and checks the anode invariant every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        check("an_onehot", 12'($countones(~An) > 1), 12'd0);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("an", {8'h00, An}, {8'h00, e.an});
            check("cout", {4'h0, Cout}, {4'h0, e.cout});
            check("frame_start", {11'h000, frame_start}, {11'h000, e.fs});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_an", {8'h00, An}, 12'h00F);
        check("rst_cout", {4'h0, Cout}, 12'h0FF);
        check("rst_fs", {11'h000, frame_start}, 12'h000);
        #1 rst = 1'b0;

        // Basic scan and mid-frame input change
        cur_d = 16'h4321; cur_dp = 4'b0000;
        run(2 * FRAME);
        run_to_lit(1);
        cur_d = 16'h9999;
        run(FRAME + 8);

        // Hex codes and decimal points
        cur_d = 16'hFEDC;
        run(FRAME + 8);
        cur_d = 16'h0000; cur_dp = 4'b0100;
        run(FRAME + 8);

        // Disable for 5 cycles during digit 2, then resume
        cur_d = 16'h8765; cur_dp = 4'b1001;
        run_to_lit(2);
        for (int k = 0; k < 5; k++) step(1'b0);
        run(FRAME + 4);

        // Random traffic with occasional disables
        for (int r = 0; r < 20; r++) begin
            cur_d  = 16'($urandom);
            cur_dp = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) step(1'b0);
            end
            run(int'($urandom_range(1, 40)));
        end

        // Asynchronous reset in the middle of a lit slot
        cur_d = 16'h2468; cur_dp = 4'b0010;
        run(FRAME);
        run_to_lit(1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", {8'h00, An}, 12'h00F);
        check("async_rst_cout", {4'h0, Cout}, 12'h0FF);
        check("async_rst_fs", {11'h000, frame_start}, 12'h000);
        #1 rst = 1'b0;
        t = 0; snap_d = 16'h0000; snap_dp = 4'b0000;
        run(FRAME + 8);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 12'(q.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
